// File: rtl/param_rom_sorter_if.sv
// Start/done handshake plus ROM read and RAM write buses for param_rom_sorter.
// slave is the sorter side; master is the controller/memory side.
interface param_rom_sorter_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
);
  logic             start;
  logic             mode;
  logic [AW-1:0]    rom_addr;
  logic [WIDTH-1:0] rom_data;
  logic             ram_we;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_din;
  logic             busy;
  logic             done;

  modport master (
    output start, mode, rom_data,
    input  rom_addr, ram_we, ram_addr, ram_din, busy, done
  );

  modport slave (
    input  start, mode, rom_data,
    output rom_addr, ram_we, ram_addr, ram_din, busy, done
  );
endinterface

// File: rtl/param_rom_sorter.sv
// Loads DEPTH words from a combinational ROM, bubble-sorts them one compare per cycle and
// writes them to RAM 0..DEPTH-1. Define SORTER_EARLY_EXIT_EN to stop after a swap-free pass.
module param_rom_sorter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  param_rom_sorter_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LastIdx  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] LastPass = AW'(DEPTH - 2);

  typedef enum logic [2:0] {StIdle, StLoad, StSort, StStore, StDone} state_e;

  state_e           state_q;
  logic             mode_q;
  logic [AW-1:0]    pass_q;
  logic [AW-1:0]    idx_q;
  logic [WIDTH-1:0] data_q   [DEPTH];
  logic [WIDTH-1:0] data_nxt [DEPTH];
  logic [AW-1:0]    idx_inc;
  logic [AW-1:0]    store_inc;
  logic             swap;
  logic             pass_end;
  logic             pass_clean;

  assign idx_inc   = idx_q + AW'(1);
  assign store_inc = bus.ram_addr + AW'(1);
  assign pass_end  = (idx_q == (LastPass - pass_q));

  // Compare-swap of the current pair; the buffer with the swap applied feeds the store path
  // so the first RAM word is correct even when the final compare swapped it.
  always_comb begin
    data_nxt = data_q;
    swap     = 1'b0;
    if (state_q == StSort) begin
      if (mode_q) swap = (data_q[idx_q] < data_q[idx_inc]);
      else        swap = (data_q[idx_q] > data_q[idx_inc]);
      if (swap) begin
        data_nxt[idx_q]   = data_q[idx_inc];
        data_nxt[idx_inc] = data_q[idx_q];
      end
    end
  end

`ifdef SORTER_EARLY_EXIT_EN
  logic swapped_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swapped_q <= 1'b0;
    end else if (state_q != StSort || pass_end) begin
      swapped_q <= 1'b0;
    end else if (swap) begin
      swapped_q <= 1'b1;
    end
  end

  assign pass_clean = ~(swapped_q | swap);
`else
  assign pass_clean = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      mode_q       <= 1'b0;
      pass_q       <= '0;
      idx_q        <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) data_q[i] <= '0;
      bus.rom_addr <= '0;
      bus.ram_we   <= 1'b0;
      bus.ram_addr <= '0;
      bus.ram_din  <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q      <= StLoad;
            mode_q       <= bus.mode;
            pass_q       <= '0;
            idx_q        <= '0;
            bus.rom_addr <= '0;
            bus.busy     <= 1'b1;
          end
        end
        StLoad: begin
          // rom_addr doubles as the load counter
          data_q[bus.rom_addr] <= bus.rom_data;
          if (bus.rom_addr == LastIdx) begin
            state_q      <= StSort;
            bus.rom_addr <= '0;
          end else begin
            bus.rom_addr <= bus.rom_addr + AW'(1);
          end
        end
        StSort: begin
          data_q <= data_nxt;
          if (pass_end) begin
            if (pass_q == LastPass || pass_clean) begin
              state_q      <= StStore;
              bus.ram_we   <= 1'b1;
              bus.ram_addr <= '0;
              bus.ram_din  <= data_nxt[0];
            end else begin
              pass_q <= pass_q + AW'(1);
              idx_q  <= '0;
            end
          end else begin
            idx_q <= idx_inc;
          end
        end
        StStore: begin
          if (bus.ram_addr == LastIdx) begin
            state_q    <= StDone;
            bus.ram_we <= 1'b0;
            bus.done   <= 1'b1;
          end else begin
            bus.ram_addr <= store_inc;
            bus.ram_din  <= data_q[store_inc];
          end
        end
        StDone: begin
          state_q  <= StIdle;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_param_rom_sorter.sv
// Bench for param_rom_sorter: a behavioural model predicts every cycle of each run from the
// ROM contents, and a negedge compare process checks the DUT against it.
module tb_param_rom_sorter;
  localparam int W      = 8;
  localparam int D      = 8;
  localparam int S_FULL = D * (D - 1) / 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  param_rom_sorter_if #(.WIDTH(W), .DEPTH(D)) bus ();
  param_rom_sorter #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [W-1:0] rom_mem [D];
  logic [W-1:0] ram_mem [D];
  logic [W-1:0] exp_ram [D];
  assign bus.rom_data = rom_mem[bus.rom_addr];

  int n_checks = 0;
  int n_errors = 0;
  int wr_count = 0;
  int done_count = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  function automatic bit out_of_order(input logic [W-1:0] x, input logic [W-1:0] y,
                                      input logic md);
    return md ? (x < y) : (x > y);
  endfunction

  // Model: m_exp gets the sorted ROM contents; returns the number of SORT cycles.
  logic [W-1:0] m_exp [D];
  function automatic int model_run(input logic md);
    logic [W-1:0] a [D];
    logic [W-1:0] t;
    int j;
    for (int i = 0; i < D; i++) a[i] = rom_mem[i];
    for (int i = 1; i < D; i++) begin
      j = i;
      while (j > 0 && out_of_order(a[j-1], a[j], md)) begin
        t = a[j]; a[j] = a[j-1]; a[j-1] = t;
        j--;
      end
    end
    for (int i = 0; i < D; i++) m_exp[i] = a[i];
`ifdef SORTER_EARLY_EXIT_EN
    begin
      logic [W-1:0] b [D];
      int cyc;
      bit sw;
      for (int i = 0; i < D; i++) b[i] = rom_mem[i];
      cyc = 0;
      for (int p = 0; p < D - 1; p++) begin
        sw = 1'b0;
        for (int k = 0; k < D - 1 - p; k++) begin
          cyc++;
          if (out_of_order(b[k], b[k+1], md)) begin
            t = b[k]; b[k] = b[k+1]; b[k+1] = t;
            sw = 1'b1;
          end
        end
        if (!sw) break;
      end
      return cyc;
    end
`else
    return S_FULL;
`endif
  endfunction

  // Cycle 1 is the first cycle after the accept edge; done is expected in cycle m_t.
  int   m_c = 0;
  int   m_t = 0;
  int   m_s = 0;
  logic m_active = 1'b0;
  logic m_fresh = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_fresh  = 1'b1;
      m_c      = 0;
    end else if (m_active) begin
      if (m_c == m_t) m_active = 1'b0;
      else m_c++;
    end else if (bus.start) begin
      m_s      = model_run(bus.mode);
      m_t      = 2 * D + m_s + 1;
      m_c      = 1;
      m_active = 1'b1;
      m_fresh  = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic e_we;
      int k;
      e_we = m_active && (m_c >= D + m_s + 1) && (m_c <= 2 * D + m_s);
      check("busy", bus.busy, m_active);
      check("done", bus.done, m_active && (m_c == m_t));
      check("ram_we", bus.ram_we, e_we);
      if (m_active && m_c <= D) check("rom_addr", bus.rom_addr, m_c - 1);
      if (e_we) begin
        k = m_c - (D + m_s + 1);
        check("ram_addr", bus.ram_addr, k);
        check("ram_din", bus.ram_din, m_exp[k]);
      end
      if (m_fresh) begin
        check("idle_rom_addr", bus.rom_addr, 0);
        check("idle_ram_addr", bus.ram_addr, 0);
        check("idle_ram_din", bus.ram_din, 0);
      end
    end
  end

  always @(posedge clk) begin
    if (bus.ram_we) begin
      ram_mem[bus.ram_addr] <= bus.ram_din;
      wr_count <= wr_count + 1;
    end
    if (bus.done) done_count <= done_count + 1;
  end

  task automatic set_rom(input int v0, v1, v2, v3, v4, v5, v6, v7);
    rom_mem[0] = W'(v0); rom_mem[1] = W'(v1); rom_mem[2] = W'(v2); rom_mem[3] = W'(v3);
    rom_mem[4] = W'(v4); rom_mem[5] = W'(v5); rom_mem[6] = W'(v6); rom_mem[7] = W'(v7);
  endtask

  task automatic set_exp(input int v0, v1, v2, v3, v4, v5, v6, v7);
    exp_ram[0] = W'(v0); exp_ram[1] = W'(v1); exp_ram[2] = W'(v2); exp_ram[3] = W'(v3);
    exp_ram[4] = W'(v4); exp_ram[5] = W'(v5); exp_ram[6] = W'(v6); exp_ram[7] = W'(v7);
  endtask

  // exp_cyc < 0 takes latency and RAM contents from the model instead of literals.
  task automatic do_run(input string nm, input logic md, input int exp_cyc, input int poke);
    int cyc;
    int wr0;
    int dn0;
    wr0 = wr_count;
    dn0 = done_count;
    @(negedge clk);
    bus.mode  = md;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (!bus.done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (poke > 0 && cyc == poke) begin
        bus.start = 1'b1;
        bus.mode  = ~md;
      end
      if (poke > 0 && cyc == poke + 1) bus.start = 1'b0;
    end
    check({nm, "_done_cycle"}, cyc, (exp_cyc < 0) ? m_t : exp_cyc);
    if (exp_cyc < 0) for (int i = 0; i < D; i++) exp_ram[i] = m_exp[i];
    @(negedge clk);
    check({nm, "_busy_after_done"}, bus.busy, 0);
    check({nm, "_writes"}, wr_count - wr0, D);
    check({nm, "_done_pulses"}, done_count - dn0, 1);
    for (int i = 0; i < D; i++) check({nm, "_ram_word"}, ram_mem[i], exp_ram[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    for (int i = 0; i < D; i++) begin
      rom_mem[i] = '0;
      ram_mem[i] = '0;
    end
    repeat (2) @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_ram_we", bus.ram_we, 0);
    check("reset_rom_addr", bus.rom_addr, 0);
    check("reset_ram_addr", bus.ram_addr, 0);
    check("reset_ram_din", bus.ram_din, 0);
    #1 rst_n = 1'b1;

    // Pin the model against hand-computed latencies.
    set_rom(5, 3, 8, 1, 9, 2, 7, 4);
`ifndef SORTER_EARLY_EXIT_EN
    check("model_latency_full", 2 * D + model_run(1'b0) + 1, 45);
`endif
    set_rom(1, 2, 3, 4, 5, 6, 7, 8);
`ifdef SORTER_EARLY_EXIT_EN
    check("model_latency_sorted", 2 * D + model_run(1'b0) + 1, 24);
    lat = 24;
`else
    lat = 45;
`endif

    set_rom(5, 3, 8, 1, 9, 2, 7, 4);
    set_exp(1, 2, 3, 4, 5, 7, 8, 9);
`ifdef SORTER_EARLY_EXIT_EN
    do_run("t1_asc", 1'b0, -1, 0);
`else
    do_run("t1_asc", 1'b0, 45, 0);
`endif

    set_exp(9, 8, 7, 5, 4, 3, 2, 1);
`ifdef SORTER_EARLY_EXIT_EN
    do_run("t2_desc", 1'b1, -1, 0);
`else
    do_run("t2_desc", 1'b1, 45, 0);
`endif

    set_rom(3, 3, 0, 255, 3, 0, 255, 1);
    set_exp(0, 0, 1, 3, 3, 3, 255, 255);
    do_run("t3_dups", 1'b0, -1, 0);

    set_rom(5, 3, 8, 1, 9, 2, 7, 4);
    set_exp(1, 2, 3, 4, 5, 7, 8, 9);
    do_run("t4_poke", 1'b0, -1, 10);

    // Reset during SORT, then a clean run.
    set_rom(10, 40, 20, 30, 70, 60, 50, 0);
    @(negedge clk);
    bus.mode  = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_busy", bus.busy, 0);
    check("t5_rst_ram_we", bus.ram_we, 0);
    #1 rst_n = 1'b1;
    begin
      int wr0;
      wr0 = wr_count;
      repeat (6) @(negedge clk);
      check("t5_no_writes", wr_count - wr0, 0);
    end
    set_exp(70, 60, 50, 40, 30, 20, 10, 0);
    do_run("t5_after_rst", 1'b1, -1, 0);

    set_rom(1, 2, 3, 4, 5, 6, 7, 8);
    set_exp(1, 2, 3, 4, 5, 6, 7, 8);
    do_run("t6_sorted", 1'b0, lat, 0);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < D; i++)
        rom_mem[i] = (r % 2 == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 3));
      do_run("rand", 1'($urandom_range(0, 1)), -1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
